mux_scan_ctrl: RTL



---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_ctrl_if.sv | 38 +++
 rtl/mux_scan_settle_cnt.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_VALID
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Mux-side and downstream handshake signals of the scan controller.
// The data_par signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              cont_en;
    logic              busy;
    logic [SEL_W-1:0]  sel;
    logic              mux_y;
    logic [NUM_CH-1:0] data;
    logic              data_valid;
    logic              data_ready;
`ifdef MUX_SCAN_PARITY_EN
    logic              data_par;

    modport master (
        input  start, cont_en, mux_y, data_ready,
        output sel, data, data_valid, busy, data_par
    );

    modport slave (
        output start, cont_en, mux_y, data_ready,
        input  sel, data, data_valid, busy, data_par
    );
`else
    modport master (
        input  start, cont_en, mux_y, data_ready,
        output sel, data, data_valid, busy
    );

    modport slave (
        output start, cont_en, mux_y, data_ready,
        input  sel, data, data_valid, busy
    );
`endif

endinterface

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter timing the settle window; done_c is high at zero.
module mux_scan_settle_cnt
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four inputs of a 4:1 mux and presents the sampled word on a valid/ready port.
// Define MUX_SCAN_PARITY_EN to add the data_par output (XOR of data).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = SKIP_SETTLE ? CNT_W'(0) : CNT_W'(SETTLE_CYCLES - 1);
    localparam state_e           FIRST_ST    = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

    state_e            state;
    state_e            state_nxt;
    logic [SEL_W-1:0]  channel;
    logic [SEL_W-1:0]  channel_nxt;
    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] shadow_nxt;
    logic              accept_c;
    logic              last_sample_c;
    logic              scanning_nxt_c;
    logic              settle_load_c;
    logic              settle_dec_c;
    logic              settle_done_c;

    mux_scan_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load_c),
        .load_val (SETTLE_LOAD),
        .dec      (settle_dec_c),
        .done_c   (settle_done_c)
    );

    // Next-state, channel advance and shadow capture.
    always_comb begin
        state_nxt     = state;
        channel_nxt   = channel;
        shadow_nxt    = shadow;
        accept_c      = bus.data_valid && bus.data_ready;
        last_sample_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt   = FIRST_ST;
                    channel_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_done_c) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                shadow_nxt[channel] = bus.mux_y;
                if (channel == LAST_CH) begin
                    last_sample_c = 1'b1;
                    state_nxt     = ST_VALID;
                end else begin
                    channel_nxt = channel + SEL_W'(1);
                    state_nxt   = FIRST_ST;
                end
            end
            ST_VALID: begin
                if (accept_c) begin
                    channel_nxt = '0;
                    state_nxt   = bus.cont_en ? FIRST_ST : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        scanning_nxt_c = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
        settle_load_c  = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
        settle_dec_c   = (state == ST_SETTLE) && !settle_done_c;
    end

    // State and registered outputs; sel/busy track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            channel        <= '0;
            shadow         <= '0;
            bus.sel        <= '0;
            bus.busy       <= 1'b0;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            bus.data_par   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            channel  <= channel_nxt;
            shadow   <= shadow_nxt;
            bus.sel  <= scanning_nxt_c ? channel_nxt : '0;
            bus.busy <= scanning_nxt_c;
            if (last_sample_c) begin
                bus.data       <= shadow_nxt;
                bus.data_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                bus.data_par   <= ^shadow_nxt;
`endif
            end else if (accept_c) begin
                bus.data_valid <= 1'b0;
            end
        end
    end

endmodule
